key_event_decoder: RTL

Sits directly downstream of the key debouncer and upstream of the beep/LED control logic. It consumes the debouncer's one-cycle change strobe and stable key level. It classifies each press as short press, long press or double click, and emits a one-cycle pulse per event. Consumers then react to gestures instead of raw edges.

---
 rtl/key_event_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/key_event_decoder.sv
// key_event_decoder
//
// Turns the debouncer's change strobe and stable key level into gesture
// events: short press, long press, double click and (optionally) auto-repeat
// while a long press is held. Each event is a registered one-cycle pulse.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   : HOLD counts REPEAT_CYC periods and pulses key_repeat
//   undefined : key_repeat is constant 0 and HOLD does not count
//
// Ports:
//   clk          system clock, single domain
//   rst_n        synchronous active-low reset
//   key_flag     one-cycle strobe: debounced key level changed
//   key_value    debounced key level (0 = pressed, 1 = released)
//   short_press  pulse: single short press completed
//   long_press   pulse: hold reached LONG_CYC
//   double_click pulse: second press released inside the window
//   key_repeat   pulse: auto-repeat while held after a long press
//   busy         high whenever the FSM is not IDLE
//
// Handshake: key_flag is a strobe with no back-pressure; key_value is only
// meaningful in a cycle where key_flag is high. Every output is a plain
// registered level/pulse with no acknowledge.
//
// The current state is held in state_q (typed enum) for checkers to bind to.

module key_event_decoder #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int DBL_CYC    = 15_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CNT_W      = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_flag,
  input  logic key_value,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_repeat,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_d, long_d, dbl_d, rep_d, busy_d;

  logic press_ev, release_ev;
  assign press_ev   = key_flag & ~key_value;
  assign release_ev = key_flag &  key_value;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rep_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A release seen here is spurious and deliberately dropped.
        if (press_ev) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        // Release is checked first so it wins over the terminal count.
        if (release_ev) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (release_ev) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef KEY_REPEAT_EN
        // Release above suppresses a repeat due in the same cycle.
        else if (cnt_q == REPEAT_LAST) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WAIT2: begin
        // A second press coinciding with the timeout still counts.
        if (press_ev) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == DBL_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS2: begin
        // Untimed: a held second press never becomes a long press.
        if (release_ev) begin
          dbl_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_press  <= short_d;
      long_press   <= long_d;
      double_click <= dbl_d;
      busy         <= busy_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) key_repeat <= 1'b0;
    else        key_repeat <= rep_d;
  end
`else
  assign key_repeat = 1'b0;
  // Repeat period and strobe exist only for the optional feature.
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_LAST, rep_d};
`endif

endmodule
